// File: rtl/dmg_lcd_pkg.sv
// Shared types and defaults for the DMG-style LCD scan generator.
// Geometry defaults match the original 160x144 panel.
package dmg_lcd_pkg;

  localparam int DEF_H_ACTIVE = 160;
  localparam int DEF_H_BLANK  = 48;
  localparam int DEF_V_ACTIVE = 144;
  localparam int DEF_V_BLANK  = 10;
  localparam int DEF_CLK_DIV  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmg_lcd_timing.sv
// Slot/line/frame counters for the LCD scan generator.
// Exposes next-state counter values so the top can register its outputs.
module dmg_lcd_timing
  import dmg_lcd_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_ACTIVE + DEF_H_BLANK,
  parameter int V_TOTAL = DEF_V_ACTIVE + DEF_V_BLANK,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SW      = cw(CLK_DIV),
  parameter int HW      = cw(H_TOTAL),
  parameter int VW      = cw(V_TOTAL)
) (
  input  logic          clk_8m,
  input  logic          rst_n,
  input  logic          i_run,
  output logic [SW-1:0] o_sc,
  output logic [SW-1:0] o_sc_nxt,
  output logic [HW-1:0] o_hc_nxt,
  output logic [VW-1:0] o_vc_nxt,
  output logic          o_frame_end
);

  localparam logic [SW-1:0] SC_MAX = SW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HC_MAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VC_MAX = VW'(V_TOTAL - 1);

  logic [SW-1:0] r_sc;
  logic [HW-1:0] r_hc;
  logic [VW-1:0] r_vc;
  logic          w_slot_end;
  logic          w_line_end;

  assign w_slot_end  = i_run && (r_sc == SC_MAX);
  assign w_line_end  = w_slot_end && (r_hc == HC_MAX);
  assign o_frame_end = w_line_end && (r_vc == VC_MAX);
  assign o_sc        = r_sc;

  // Counters sit at zero whenever the generator is idle.
  always_comb begin
    o_sc_nxt = '0;
    o_hc_nxt = '0;
    o_vc_nxt = '0;
    if (i_run) begin
      o_sc_nxt = w_slot_end ? '0 : r_sc + SW'(1);
      o_hc_nxt = r_hc;
      o_vc_nxt = r_vc;
      if (w_slot_end) begin
        o_hc_nxt = w_line_end ? '0 : r_hc + HW'(1);
        if (w_line_end) begin
          o_vc_nxt = o_frame_end ? '0 : r_vc + VW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      r_sc <= '0;
      r_hc <= '0;
      r_vc <= '0;
    end else begin
      r_sc <= o_sc_nxt;
      r_hc <= o_hc_nxt;
      r_vc <= o_vc_nxt;
    end
  end

endmodule

// File: rtl/dmg_lcd_scan_gen.sv
// Parametrised DMG LCD drive-signal generator: fetch, data pipeline, syncs.
// All outputs are registered from the next-cycle counter values.
module dmg_lcd_scan_gen
  import dmg_lcd_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_BLANK      = DEF_H_BLANK,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_BLANK      = DEF_V_BLANK,
  parameter int BPP          = 2,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int RD_LAT       = 1,
  parameter int ALT_PER_LINE = 0
) (
  input  logic                                 clk_8m,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 invert,
  output logic [cw(H_ACTIVE+H_BLANK)-1:0]      pix_x,
  output logic [cw(V_ACTIVE+V_BLANK)-1:0]      pix_y,
  input  logic [BPP-1:0]                       pix_data,
  output logic                                 newframe,
  output logic                                 lcd_hsync,
  output logic                                 lcd_vsync,
  output logic                                 lcd_altsig,
  output logic                                 lcd_clk,
  output logic [BPP-1:0]                       lcd_d,
  output logic                                 lcd_datal,
  output logic                                 lcd_control
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int SW      = cw(CLK_DIV);
  localparam int HW      = cw(H_TOTAL);
  localparam int VW      = cw(V_TOTAL);

  localparam logic [HW-1:0] HA      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HA_M1   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HT_M1   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VA      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VT_M1   = VW'(V_TOTAL - 1);
  localparam logic [SW-1:0] SC_HALF = SW'(CLK_DIV / 2);
  localparam logic [SW-1:0] SC_LAT  = SW'(RD_LAT);

  state_t         r_state;
  logic           r_inv;
  logic           r_alt;
  logic [BPP-1:0] r_pend;

  logic           w_run;
  logic           w_run_nxt;
  logic [SW-1:0]  w_sc;
  logic [SW-1:0]  w_sc_nxt;
  logic [HW-1:0]  w_hc_nxt;
  logic [VW-1:0]  w_vc_nxt;
  logic [VW-1:0]  w_vc_inc;
  logic           w_frame_end;
  logic           w_ss;
  logic           w_nact;
  logic           w_nf;
  logic           w_nl;
  logic           w_inv;
  logic           w_alt;

  dmg_lcd_timing #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CLK_DIV (CLK_DIV),
    .SW      (SW),
    .HW      (HW),
    .VW      (VW)
  ) u_timing (
    .clk_8m      (clk_8m),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .o_sc        (w_sc),
    .o_sc_nxt    (w_sc_nxt),
    .o_hc_nxt    (w_hc_nxt),
    .o_vc_nxt    (w_vc_nxt),
    .o_frame_end (w_frame_end)
  );

  always_comb begin
    w_run     = (r_state == RUN);
    w_run_nxt = w_run ? !(w_frame_end && !enable) : enable;
    w_ss      = w_run_nxt && (w_sc_nxt == '0);
    w_nact    = w_run_nxt && (w_hc_nxt < HA) && (w_vc_nxt < VA);
    w_nl      = w_ss && (w_hc_nxt == '0);
    w_nf      = w_nl && (w_vc_nxt == '0);
    w_inv     = w_nf ? invert : r_inv;
    w_alt     = r_alt ^ ((ALT_PER_LINE != 0) ? w_nl : w_nf);
    w_vc_inc  = (w_vc_nxt == VT_M1) ? '0 : w_vc_nxt + VW'(1);
  end

  always_ff @(posedge clk_8m) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_inv       <= 1'b0;
      r_alt       <= 1'b0;
      r_pend      <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      newframe    <= 1'b0;
      lcd_hsync   <= 1'b0;
      lcd_vsync   <= 1'b0;
      lcd_altsig  <= 1'b0;
      lcd_clk     <= 1'b0;
      lcd_d       <= '0;
      lcd_datal   <= 1'b0;
      lcd_control <= 1'b0;
    end else begin
      r_state     <= w_run_nxt ? RUN : IDLE;
      newframe    <= w_nf;
      lcd_control <= w_run_nxt;
      lcd_clk     <= w_nact && (w_sc_nxt >= SC_HALF);
      lcd_datal   <= w_run_nxt && (w_hc_nxt == HA) && (w_vc_nxt < VA);
      lcd_hsync   <= w_run_nxt && (w_hc_nxt == HT_M1);
      lcd_vsync   <= w_run_nxt && (w_vc_nxt == '0);
      r_alt       <= w_alt;
      lcd_altsig  <= w_run_nxt && w_alt;
      if (w_nf) r_inv <= invert;
      // Idle keeps fetching pixel (0,0) so the first slot has valid data.
      if (!w_run || (w_sc == SC_LAT)) r_pend <= pix_data;
      if (w_ss) begin
        lcd_d <= w_nact ? (r_pend ^ {BPP{w_inv}}) : '0;
        if (w_hc_nxt < HA_M1) begin
          pix_x <= w_hc_nxt + HW'(1);
          pix_y <= w_vc_nxt;
        end else if (w_hc_nxt == HT_M1) begin
          pix_x <= '0;
          pix_y <= w_vc_inc;
        end
      end else if (!w_run_nxt) begin
        lcd_d <= '0;
      end
    end
  end

endmodule

// File: doc/dmg_lcd_scan_gen.md
Name: dmg_lcd_scan_gen

Overview:
- Parametrised successor to the fixed 160x144 DMG LCD controller.
- Generates the raw DMG-style LCD drive signals (hsync, vsync, altsig, pixel clock, data, data latch, control) for a configurable panel geometry, pixel depth, clock divider and pixel-source read latency.
- Sits between the pixel generators (startup screen, VRAM read port) and the LCD pins.
- Adds two features: an enable/blank mode applied only at frame boundaries, and per-line or per-frame altsig polarity inversion.

Parameters:
- H_ACTIVE, 160, visible pixels per line.
- H_BLANK, 48, non-visible slots per line (H_TOTAL = H_ACTIVE+H_BLANK).
- V_ACTIVE, 144, visible lines.
- V_BLANK, 10, blank lines (V_TOTAL = V_ACTIVE+V_BLANK).
- BPP, 2, bits per pixel on lcd_d and pix_data.
- CLK_DIV, 2, clk_8m cycles per pixel slot; even, >=2.
- RD_LAT, 1, clk_8m cycles from pix_x/pix_y change to valid pix_data; 1 <= RD_LAT < CLK_DIV.
- ALT_PER_LINE, 0, 0 = altsig toggles per frame; 1 = altsig toggles per line.

Ports:
- clk_8m  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  display enable, sampled only at frame boundary.
- invert  in  1  invert pixel data, sampled at frame start.
- pix_x  out  clog2(H_TOTAL)  x of pixel being fetched.
- pix_y  out  clog2(V_TOTAL)  y of pixel being fetched.
- pix_data  in  BPP  pixel value, valid RD_LAT cycles after pix_x/pix_y.
- newframe  out  1  one-cycle pulse at frame start.
- lcd_hsync  out  1  line sync.
- lcd_vsync  out  1  frame sync.
- lcd_altsig  out  1  LCD polarity alternation.
- lcd_clk  out  1  pixel shift clock.
- lcd_d  out  BPP  pixel data.
- lcd_datal  out  1  line data latch.
- lcd_control  out  1  panel enable.

Behaviour:
- Reset (rst_n=0 at a clk_8m edge): all counters 0; every output 0, including lcd_d, pix_x, pix_y and lcd_altsig; state IDLE.
- Counters:
  - sc: 0..CLK_DIV-1, advances each clk_8m.
  - hc: 0..H_TOTAL-1, advances when sc wraps.
  - vc: 0..V_TOTAL-1, advances when hc wraps.
  - All wrap to 0.
- States:
  - IDLE: counters held at 0, all outputs 0.
  - RUN.
- IDLE->RUN: enable=1 sampled. The first RUN cycle is sc=hc=vc=0, and newframe pulses on that cycle.
- RUN->IDLE: occurs only on the cycle where sc=CLK_DIV-1, hc=H_TOTAL-1, vc=V_TOTAL-1 and enable=0. Deasserting enable mid-frame completes the frame.
- newframe: high for exactly one clk_8m cycle at every sc=hc=vc=0 in RUN.
- invert: latched on that same cycle. It is XORed onto all BPP bits of lcd_d for the whole frame.
- lcd_control: 1 throughout RUN, 0 in IDLE.
- Active slot: hc<H_ACTIVE and vc<V_ACTIVE.
- lcd_clk: 1 when sc >= CLK_DIV/2 in an active slot, else 0.
- lcd_d:
  - Registered; changes only at sc=0. Stable for the whole slot.
  - Holds pixel hc of line vc in active slots.
  - 0 in non-active slots.
- Fetch:
  - pix_x/pix_y update at sc=0 to the coordinates of the pixel displayed in the next slot. From slot hc<H_ACTIVE-1 this is (hc+1, vc).
  - From slot hc=H_TOTAL-1 it is (0, vc+1 mod V_TOTAL).
  - Otherwise pix_x/pix_y hold their value.
  - pix_data is captured at sc=RD_LAT into a pending register and transferred to lcd_d at the next sc=0.
- lcd_datal: 1 during the whole slot hc=H_ACTIVE when vc<V_ACTIVE.
- lcd_hsync: 1 during the whole slot hc=H_TOTAL-1, on every line, both active and blank.
- lcd_vsync: 1 for the entire line vc=0, all slots.
- lcd_altsig:
  - ALT_PER_LINE=0: toggles on the first cycle of each frame.
  - ALT_PER_LINE=1: toggles on the first cycle of each line (hc=0, sc=0).
  - The first frame after reset starts with altsig=1.
- Frame length: H_TOTAL·V_TOTAL·CLK_DIV clk_8m cycles (64064 at defaults).
- Reset mid-frame: immediate return to the reset state on the next edge. No partial-line completion.

Decomposition:
- Shared package dmg_lcd_pkg holds:
  - default geometry constants: 160, 144, 48, 10, CLK_DIV;
  - the state enum {IDLE, RUN};
  - a clog2-based width function for the counters.
- One natural sub-module, dmg_lcd_timing: the sc/hc/vc counters plus slot-start and line/frame-wrap strobes. The top level handles fetch, the data pipeline and sync outputs.

Test Plan:
- Reset then enable=1, defaults -> newframe pulse at cycle 0 and every 64064 cycles; lcd_vsync high for 416 cycles per frame; lcd_control=1.
- pix_data = pix_x[1:0] with RD_LAT=1 -> lcd_d reads 0,1,2,3,0… across 160 active slots; 160 lcd_clk rising edges per active line; lcd_d=0 during blank.
- Line timing -> lcd_datal high for 2 cycles at hc=160; lcd_hsync high 2 cycles at hc=207; no lcd_clk during vc 144..153.
- invert toggled mid-frame -> no change until the next newframe, then lcd_d = ~pix_data.
- ALT_PER_LINE=0 vs 1 -> altsig toggles once per 64064 cycles vs once per 416 cycles; starts at 1.
- enable=0 at mid-frame (vc=50) -> frame completes, then IDLE with all outputs 0. rst_n=0 mid-line -> all outputs 0 on the next edge.
